// File: rtl/uart_bus_master_if.sv
// Signal bundle between uart_bus_master and its environment: UART rx/tx byte streams and the native memory bus.
// The master modport is the bridge's view. The slave modport is the view of the UART, decoder and memory.
interface uart_bus_master_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        input  rx_valid, rx_data, tx_ready, mem_rdata, mem_ready,
        output rx_ready, tx_valid, tx_data, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, mem_rdata, mem_ready,
        input  rx_ready, tx_valid, tx_data, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/uart_bus_master.sv
// UART byte-stream to memory-bus bridge: 0x57 write / 0x52 read frames, status (+read data) responses.
// Optional bus timeout is enabled with `define UART_BUS_MASTER_TIMEOUT_EN (status 0xE1).
module uart_bus_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    uart_bus_master_if.master   bus,
    output logic                busy
);
    typedef enum logic [2:0] {IDLE, RX_ADDR, RX_DATA, BUS_REQ, TX_STATUS, TX_DATA} state_t;

    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;
    localparam logic [7:0] ST_OK  = 8'h00;
    localparam logic [7:0] ST_TMO = 8'hE1;
    localparam logic [7:0] ST_CMD = 8'hEE;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("uart_bus_master: TIMEOUT_CYCLES must be in 2..65535");
    end

    state_t      state, state_nx;
    logic        cmd_wr;
    logic [1:0]  cnt;
    logic [31:0] addr, wdata, rdata;
    logic [7:0]  status, status_nx;
    logic        rx_ready, tx_valid, mem_valid;
    logic [7:0]  tx_data;
    logic [3:0]  mem_wstrb;
    logic        rx_fire, tx_fire, timeout;

    assign rx_fire = bus.rx_valid && rx_ready;
    assign tx_fire = tx_valid && bus.tx_ready;

`ifdef UART_BUS_MASTER_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    // Held at zero outside BUS_REQ so every access starts counting from 0.
    always_ff @(posedge clk) begin
        if (!reset_n || state != BUS_REQ) tmo_cnt <= '0;
        else if (!bus.mem_ready)          tmo_cnt <= tmo_cnt + 16'd1;
    end
    assign timeout = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) && !bus.mem_ready;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        status_nx = status;
        rx_ready  = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        case (state)
            IDLE: begin
                rx_ready = reset_n;
                if (rx_fire) begin
                    if (bus.rx_data == CMD_WR || bus.rx_data == CMD_RD) begin
                        state_nx = RX_ADDR;
                    end else begin
                        state_nx  = TX_STATUS;
                        status_nx = ST_CMD;
                    end
                end
            end
            RX_ADDR: begin
                rx_ready = reset_n;
                if (rx_fire && cnt == 2'd3) state_nx = cmd_wr ? RX_DATA : BUS_REQ;
            end
            RX_DATA: begin
                rx_ready = reset_n;
                if (rx_fire && cnt == 2'd3) state_nx = BUS_REQ;
            end
            BUS_REQ: begin
                mem_valid = 1'b1;
                mem_wstrb = cmd_wr ? 4'hf : 4'h0;
                // A ready in the terminal-count cycle takes priority over the timeout.
                if (bus.mem_ready) begin
                    state_nx  = TX_STATUS;
                    status_nx = ST_OK;
                end else if (timeout) begin
                    state_nx  = TX_STATUS;
                    status_nx = ST_TMO;
                end
            end
            TX_STATUS: begin
                tx_valid = 1'b1;
                tx_data  = status;
                if (tx_fire) state_nx = (!cmd_wr && status == ST_OK) ? TX_DATA : IDLE;
            end
            TX_DATA: begin
                tx_valid = 1'b1;
                case (cnt)
                    2'd0:    tx_data = rdata[31:24];
                    2'd1:    tx_data = rdata[23:16];
                    2'd2:    tx_data = rdata[15:8];
                    default: tx_data = rdata[7:0];
                endcase
                if (tx_fire && cnt == 2'd3) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_wr <= 1'b0;
            cnt    <= '0;
            addr   <= '0;
            wdata  <= '0;
            rdata  <= '0;
            status <= '0;
        end else begin
            status <= status_nx;
            case (state)
                IDLE: if (rx_fire) begin
                    cmd_wr <= (bus.rx_data == CMD_WR);
                    cnt    <= '0;
                end
                RX_ADDR: if (rx_fire) begin
                    addr <= {addr[23:0], bus.rx_data};
                    cnt  <= cnt + 2'd1;
                end
                RX_DATA: if (rx_fire) begin
                    wdata <= {wdata[23:0], bus.rx_data};
                    cnt   <= cnt + 2'd1;
                end
                BUS_REQ: begin
                    cnt <= '0;
                    if (bus.mem_ready) rdata <= bus.mem_rdata;
                end
                TX_DATA: if (tx_fire) cnt <= cnt + 2'd1;
                default: ;
            endcase
        end
    end

    assign bus.rx_ready  = rx_ready;
    assign bus.tx_valid  = tx_valid;
    assign bus.tx_data   = tx_data;
    assign bus.mem_valid = mem_valid;
    assign bus.mem_addr  = {addr[31:2], 2'b00};
    assign bus.mem_wdata = wdata;
    assign bus.mem_wstrb = mem_wstrb;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: write, read, unknown command, tx backpressure, mid-frame reset,
// and (with UART_BUS_MASTER_TIMEOUT_EN defined) bus timeout at TIMEOUT_CYCLES=16.
module tb_uart_bus_master;
    logic clk = 1'b0;
    logic reset_n;
    logic busy;
    int   n_checks = 0;
    int   n_fails  = 0;

    uart_bus_master_if bus();

    uart_bus_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the consuming posedge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("rx_ready_wait", 32'(n), 32'd0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[]);
        foreach (f[i]) send_byte(f[i]);
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp);
        int n = 0;
        while (bus.tx_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check({tag, "_wait"}, 32'(n), 32'd0);
        check(tag, 32'(bus.tx_data), 32'(exp));
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
    endtask

    initial begin
        int n;
        reset_n       = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.tx_ready  = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_rx_ready",  32'(bus.rx_ready),  32'd0);
        check("rst_tx_valid",  32'(bus.tx_valid),  32'd0);
        check("rst_tx_data",   32'(bus.tx_data),   32'd0);
        check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        check("rst_mem_addr",  bus.mem_addr,       32'd0);
        check("rst_mem_wdata", bus.mem_wdata,      32'd0);
        check("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        check("rst_busy",      32'(busy),          32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_rx_ready", 32'(bus.rx_ready), 32'd1);

        // Write, responder ready after 3 cycles
        send_frame('{8'h57, 8'hC1, 8'h00, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
        check("wr_mem_valid", 32'(bus.mem_valid), 32'd1);
        check("wr_mem_addr",  bus.mem_addr,       32'hC100_0004);
        check("wr_mem_wdata", bus.mem_wdata,      32'hDEAD_BEEF);
        check("wr_mem_wstrb", 32'(bus.mem_wstrb), 32'hf);
        check("wr_rx_ready",  32'(bus.rx_ready),  32'd0);
        repeat (2) @(negedge clk);
        check("wr_hold_valid", 32'(bus.mem_valid), 32'd1);
        check("wr_hold_addr",  bus.mem_addr,       32'hC100_0004);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        check("wr_valid_drop", 32'(bus.mem_valid), 32'd0);
        check("wr_tx_valid",   32'(bus.tx_valid),  32'd1);
        recv_byte("wr_status", 8'h00);
        check("wr_done_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("wr_done_busy",     32'(busy),          32'd0);

        // Read, low address bits dropped
        send_frame('{8'h52, 8'h40, 8'h00, 8'h00, 8'h13});
        check("rd_mem_valid", 32'(bus.mem_valid), 32'd1);
        check("rd_mem_addr",  bus.mem_addr,       32'h4000_0010);
        check("rd_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
        bus.mem_rdata = 32'h1234_5678;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        check("rd_valid_drop", 32'(bus.mem_valid), 32'd0);
        check("rd_tx_valid",   32'(bus.tx_valid),  32'd1);
        recv_byte("rd_status", 8'h00);
        recv_byte("rd_b3", 8'h12);
        recv_byte("rd_b2", 8'h34);
        recv_byte("rd_b1", 8'h56);
        recv_byte("rd_b0", 8'h78);
        check("rd_done_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rd_done_busy",     32'(busy),          32'd0);

        // Unknown command
        send_byte(8'hAA);
        check("unk_mem_valid", 32'(bus.mem_valid), 32'd0);
        recv_byte("unk_status", 8'hEE);
        check("unk_mem_valid2", 32'(bus.mem_valid), 32'd0);
        check("unk_busy",       32'(busy),          32'd0);

        // Read after unknown command, with tx backpressure mid-response
        send_frame('{8'h52, 8'h00, 8'h00, 8'h01, 8'h00});
        check("bp_mem_addr", bus.mem_addr, 32'h0000_0100);
        bus.mem_rdata = 32'hA5C3_0F96;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        recv_byte("bp_status", 8'h00);
        recv_byte("bp_b3", 8'hA5);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_valid", 32'(bus.tx_valid), 32'd1);
            check("bp_hold_data",  32'(bus.tx_data),  32'hC3);
            check("bp_rx_ready",   32'(bus.rx_ready), 32'd0);
            @(negedge clk);
        end
        recv_byte("bp_b2", 8'hC3);
        recv_byte("bp_b1", 8'h0F);
        check("bp_rx_ready_tx", 32'(bus.rx_ready), 32'd0);
        recv_byte("bp_b0", 8'h96);
        check("bp_done_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("bp_done_busy",     32'(busy),          32'd0);

        // Reset in RX_DATA after two data bytes
        send_frame('{8'h57, 8'h00, 8'h00, 8'h00, 8'h08, 8'h11, 8'h22});
        check("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mrst_rx_ready",  32'(bus.rx_ready),  32'd0);
        check("mrst_tx_valid",  32'(bus.tx_valid),  32'd0);
        check("mrst_tx_data",   32'(bus.tx_data),   32'd0);
        check("mrst_mem_valid", 32'(bus.mem_valid), 32'd0);
        check("mrst_mem_addr",  bus.mem_addr,       32'd0);
        check("mrst_mem_wdata", bus.mem_wdata,      32'd0);
        check("mrst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        check("mrst_busy",      32'(busy),          32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        send_frame('{8'h57, 8'h00, 8'h00, 8'h10, 8'h02, 8'hCA, 8'hFE, 8'hF0, 8'h0D});
        check("post_mem_valid", 32'(bus.mem_valid), 32'd1);
        check("post_mem_addr",  bus.mem_addr,       32'h0000_1000);
        check("post_mem_wdata", bus.mem_wdata,      32'hCAFE_F00D);
        check("post_mem_wstrb", 32'(bus.mem_wstrb), 32'hf);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        recv_byte("post_status", 8'h00);
        check("post_busy", 32'(busy), 32'd0);

`ifdef UART_BUS_MASTER_TIMEOUT_EN
        // Timeout: mem_ready never arrives
        send_frame('{8'h52, 8'h00, 8'h00, 8'h00, 8'h20});
        n = 0;
        while (bus.mem_valid === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tmo_valid_cycles", 32'(n), 32'd16);
        recv_byte("tmo_status", 8'hE1);
        check("tmo_no_data", 32'(bus.tx_valid), 32'd0);
        check("tmo_busy",    32'(busy),          32'd0);

        // Ready on the terminal-count cycle wins
        send_frame('{8'h52, 8'h00, 8'h00, 8'h00, 8'h24});
        repeat (15) @(negedge clk);
        check("tmo_last_valid", 32'(bus.mem_valid), 32'd1);
        bus.mem_rdata = 32'h0BAD_F00D;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        check("tmo_ok_valid_drop", 32'(bus.mem_valid), 32'd0);
        recv_byte("tmo_ok_status", 8'h00);
        recv_byte("tmo_ok_b3", 8'h0B);
        recv_byte("tmo_ok_b2", 8'hAD);
        recv_byte("tmo_ok_b1", 8'hF0);
        recv_byte("tmo_ok_b0", 8'h0D);
        check("tmo_ok_busy", 32'(busy), 32'd0);
`else
        n = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
